// File: rtl/ts_packet_scheduler_if.sv
// Byte-path bundle between the TS packet scheduler, the four channel packet
// buffers and the muxed byte output.
// master: scheduler side (pops buffers, drives output bytes and status).
// slave : environment side (byte pacing, channel status, buffer read data).
interface ts_packet_scheduler_if;
  logic        byte_stb;     // one-cycle byte-slot tick
  logic [3:0]  ch_enable;    // per-channel enable mask
  logic [3:0]  pkt_ready;    // channel k holds a complete packet
  logic [3:0]  rd_en;        // one-hot pop strobe to channel buffers
  logic [31:0] rd_data;      // channel k byte on [8k+7:8k], cycle after rd_en[k]
  logic [7:0]  data_out;     // muxed TS byte
  logic        d_valid_out;  // data_out valid pulse
  logic        p_sync_out;   // byte 0 of a packet
  logic [1:0]  grant;        // channel owning the output
  logic        grant_valid;  // channel packet in progress
  logic [3:0]  sync_err;     // granted channel byte 0 was not 0x47

  modport master (
    input  byte_stb, ch_enable, pkt_ready, rd_data,
    output rd_en, data_out, d_valid_out, p_sync_out, grant, grant_valid, sync_err
  );

  modport slave (
    output byte_stb, ch_enable, pkt_ready, rd_data,
    input  rd_en, data_out, d_valid_out, p_sync_out, grant, grant_valid, sync_err
  );
endinterface

// File: rtl/ts_packet_scheduler.sv
// Packet-level round-robin scheduler for the 4-channel TS mux output path.
// Latency: byte strobe at cycle n -> rd_en at n, rd_data sampled n+1, output byte at n+2.
// Backpressure: none; byte_stb paces everything, one byte per strobe, no stalls.
// Ports: clk, rst_n (async active-low), bus (ts_packet_scheduler_if.master).
module ts_packet_scheduler #(
  parameter int PKT_LEN = 188,
  parameter bit NULL_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ts_packet_scheduler_if.master  bus
);

  localparam int CW = $clog2(PKT_LEN);

  typedef enum logic [1:0] {IDLE, SEND_CH, SEND_NULL} state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [1:0]    last_grant;

  logic [3:0]    eligible;
  logic          pick_vld;
  logic [1:0]    pick_ch;
  logic [1:0]    cand;
  logic          start_ch;
  logic          consume;
  logic [3:0]    rd_en_c;
  logic [CW-1:0] null_idx;
  logic [7:0]    null_byte;

  // First-stage pipeline: describes the byte whose source data arrives next cycle.
  logic          s1_vld;
  logic          s1_sop;
  logic          s1_null;
  logic [1:0]    s1_ch;
  logic [7:0]    s1_nbyte;
  logic [7:0]    byte_mux;

  // Round-robin search starting after last_grant. Walk from the farthest
  // candidate to the nearest so the nearest eligible channel wins.
  always_comb begin
    eligible = bus.pkt_ready & bus.ch_enable;
    pick_vld = 1'b0;
    pick_ch  = last_grant;
    cand     = last_grant;
    for (int i = 4; i >= 1; i--) begin
      cand = last_grant + 2'(i);
      if (eligible[cand]) begin
        pick_vld = 1'b1;
        pick_ch  = cand;
      end
    end
  end

  assign start_ch = (state == IDLE) && bus.byte_stb && pick_vld;
  // A strobe produces a byte unless we idle with nothing eligible and nulls disabled.
  assign consume  = bus.byte_stb && ((state != IDLE) || pick_vld || NULL_EN);

  // Pop strobe is combinational so the buffer can present data next cycle.
  always_comb begin
    rd_en_c = 4'b0000;
    if (state == SEND_CH && bus.byte_stb) begin
      rd_en_c[bus.grant] = 1'b1;
    end else if (start_ch) begin
      rd_en_c[pick_ch] = 1'b1;
    end
  end
  assign bus.rd_en = rd_en_c;

  // Null packet header 47 1F FF 10, then stuffing.
  always_comb begin
    null_idx = (state == IDLE) ? '0 : byte_cnt;
    if (null_idx == CW'(0))      null_byte = 8'h47;
    else if (null_idx == CW'(1)) null_byte = 8'h1F;
    else if (null_idx == CW'(3)) null_byte = 8'h10;
    else                         null_byte = 8'hFF;
  end

  // Packet FSM: arbitration at packet boundaries, byte counting within a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      last_grant      <= 2'd3;
      bus.grant       <= 2'd0;
      bus.grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.byte_stb) begin
            if (pick_vld) begin
              state           <= SEND_CH;
              bus.grant       <= pick_ch;
              last_grant      <= pick_ch;
              bus.grant_valid <= 1'b1;
              byte_cnt        <= CW'(1);
            end else if (NULL_EN) begin
              state    <= SEND_NULL;
              byte_cnt <= CW'(1);
            end
          end
        end
        SEND_CH, SEND_NULL: begin
          if (bus.byte_stb) begin
            if (byte_cnt == CW'(PKT_LEN - 1)) begin
              byte_cnt        <= '0;
              state           <= IDLE;
              bus.grant_valid <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_mux = s1_null ? s1_nbyte : bus.rd_data[{s1_ch, 3'b000} +: 8];

  // Two-stage byte pipeline; nulls travel the same path to keep latency uniform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld          <= 1'b0;
      s1_sop          <= 1'b0;
      s1_null         <= 1'b0;
      s1_ch           <= 2'd0;
      s1_nbyte        <= 8'h00;
      bus.data_out    <= 8'h00;
      bus.d_valid_out <= 1'b0;
      bus.p_sync_out  <= 1'b0;
      bus.sync_err    <= 4'b0000;
    end else begin
      s1_vld   <= consume;
      s1_sop   <= consume && (state == IDLE);
      s1_null  <= !((state == SEND_CH) || start_ch);
      s1_ch    <= start_ch ? pick_ch : bus.grant;
      s1_nbyte <= null_byte;

      if (s1_vld) begin
        bus.data_out <= byte_mux;
      end
      bus.d_valid_out <= s1_vld;
      bus.p_sync_out  <= s1_vld && s1_sop;
      // Flag a bad sync byte but forward the packet untouched.
      bus.sync_err    <= (s1_vld && s1_sop && !s1_null && (byte_mux != 8'h47))
                         ? (4'b0001 << s1_ch) : 4'b0000;
    end
  end

endmodule
